frame_buffer_pp: RTL and testbench

//   Multi-channel ping-pong frame buffer between the decimating FIR outputs and the FFT.

---
 rtl/frame_buffer_pp.sv | 178 +++++++++++++++++
 tb/tb_frame_buffer_pp.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_pp.sv
// Ping-pong frame buffer: captures one frame of N samples per channel into one bank
// while the other bank streams out channel by channel, natural or bit-reversed order.
module frame_buffer_pp #(
  parameter int N          = 1024,
  parameter int DATA_WIDTH = 14,
  parameter int NCHAN      = 2,
  parameter int BITREV     = 0,
  localparam int AW        = $clog2(N),
  localparam int CW        = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          frame_start_i,
  input  logic                          wr_valid_i,
  input  logic [NCHAN*DATA_WIDTH-1:0]   wr_data_i,
  output logic                          rd_valid_o,
  input  logic                          rd_ready_i,
  output logic signed [DATA_WIDTH-1:0]  rd_data_o,
  output logic [CW-1:0]                 rd_chan_o,
  output logic [AW-1:0]                 rd_idx_o,
  output logic                          rd_last_o,
  output logic                          drop_o,
  output logic [7:0]                    drop_count_o
);

  typedef enum logic {W_IDLE, W_FILL} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_STREAM} rstate_t;

  wstate_t       wstate, wstate_n;
  rstate_t       rstate, rstate_n;
  logic [AW-1:0] wr_ctr, wr_ctr_n, waddr_idx;
  logic [AW-1:0] idx_ctr, idx_ctr_n;
  logic [CW-1:0] chan_ctr, chan_ctr_n;
  logic          wbank, rbank;
  logic [1:0]    full, full_n;
  logic          we, re, wr_done, rd_done, drop_n, last_word;
  logic [AW:0]   waddr, raddr;
  logic [NCHAN*DATA_WIDTH-1:0] rd_q_p1;
  logic signed [DATA_WIDTH-1:0] rd_word;

  function automatic logic [AW-1:0] addr_map(input logic [AW-1:0] idx);
    logic [AW-1:0] r;
    for (int b = 0; b < AW; b++) r[b] = idx[AW-1-b];
    return (BITREV != 0) ? r : idx;
  endfunction

  // Write side: a new start always restarts at index 0, the start-cycle sample included
  always_comb begin
    wstate_n  = wstate;
    wr_ctr_n  = wr_ctr;
    waddr_idx = wr_ctr;
    we        = 1'b0;
    wr_done   = 1'b0;
    drop_n    = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (frame_start_i) begin
          if (full[wbank]) begin
            drop_n = 1'b1;
          end else begin
            wstate_n  = W_FILL;
            waddr_idx = '0;
            we        = wr_valid_i;
            wr_ctr_n  = wr_valid_i ? AW'(1) : '0;
          end
        end
      end
      W_FILL: begin
        if (frame_start_i) begin
          drop_n    = 1'b1;
          waddr_idx = '0;
          we        = wr_valid_i;
          wr_ctr_n  = wr_valid_i ? AW'(1) : '0;
        end else if (wr_valid_i) begin
          we       = 1'b1;
          wr_ctr_n = wr_ctr + 1'b1;
          if (wr_ctr == AW'(N-1)) begin
            wr_done  = 1'b1;
            wstate_n = W_IDLE;
          end
        end
      end
      default: wstate_n = W_IDLE;
    endcase
  end

  // Read side: the RAM output register doubles as the holding register under stall
  assign last_word = (chan_ctr == CW'(NCHAN-1)) && (idx_ctr == AW'(N-1));

  always_comb begin
    rstate_n   = rstate;
    chan_ctr_n = chan_ctr;
    idx_ctr_n  = idx_ctr;
    re         = 1'b0;
    rd_done    = 1'b0;
    case (rstate)
      R_IDLE: if (full[rbank]) rstate_n = R_ADDR;
      R_ADDR: begin
        re         = 1'b1;
        chan_ctr_n = '0;
        idx_ctr_n  = '0;
        rstate_n   = R_STREAM;
      end
      R_STREAM: begin
        if (rd_ready_i) begin
          if (last_word) begin
            rd_done  = 1'b1;
            rstate_n = full[~rbank] ? R_ADDR : R_IDLE;
          end else begin
            re        = 1'b1;
            idx_ctr_n = idx_ctr + 1'b1;
            if (idx_ctr == AW'(N-1)) chan_ctr_n = chan_ctr + 1'b1;
          end
        end
      end
      default: rstate_n = R_IDLE;
    endcase
  end

  always_comb begin
    full_n = full;
    if (wr_done) full_n[wbank] = 1'b1;
    if (rd_done) full_n[rbank] = 1'b0;
  end

  assign waddr = {wbank, waddr_idx};
  assign raddr = {rbank, addr_map(idx_ctr_n)};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wstate       <= W_IDLE;
      rstate       <= R_IDLE;
      wr_ctr       <= '0;
      idx_ctr      <= '0;
      chan_ctr     <= '0;
      wbank        <= 1'b0;
      rbank        <= 1'b0;
      full         <= '0;
      drop_o       <= 1'b0;
      drop_count_o <= '0;
    end else begin
      wstate   <= wstate_n;
      rstate   <= rstate_n;
      wr_ctr   <= wr_ctr_n;
      idx_ctr  <= idx_ctr_n;
      chan_ctr <= chan_ctr_n;
      full     <= full_n;
      drop_o   <= drop_n;
      if (wr_done) wbank <= ~wbank;
      if (rd_done) rbank <= ~rbank;
      if (drop_n && drop_count_o != 8'hFF) drop_count_o <= drop_count_o + 8'd1;
    end
  end

  // Memory stage: one RAM per channel, all channels written together, read at p1
  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    logic signed [DATA_WIDTH-1:0] mem [2*N];
    logic signed [DATA_WIDTH-1:0] q_p1;
    always_ff @(posedge clk_i) begin
      if (we) mem[waddr] <= wr_data_i[c*DATA_WIDTH +: DATA_WIDTH];
      if (re) q_p1 <= mem[raddr];
    end
    assign rd_q_p1[c*DATA_WIDTH +: DATA_WIDTH] = q_p1;
  end

  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NCHAN; c++)
      if (int'(chan_ctr) == c) rd_word = rd_q_p1[c*DATA_WIDTH +: DATA_WIDTH];
  end

  assign rd_valid_o = (rstate == R_STREAM);
  assign rd_data_o  = rd_valid_o ? rd_word : '0;
  assign rd_chan_o  = rd_valid_o ? chan_ctr : '0;
  assign rd_idx_o   = rd_valid_o ? addr_map(idx_ctr) : '0;
  assign rd_last_o  = rd_valid_o && (idx_ctr == AW'(N-1));

endmodule

// File: tb/tb_frame_buffer_pp.sv
// Scoreboard bench for frame_buffer_pp: natural-order and bit-reversed instances driven
// with identical frames; expected words queued per frame and compared as they stream out.
module tb_frame_buffer_pp;

  logic clk = 1'b0;
  logic rst, frame_start, wr_valid, rd_ready;
  logic [27:0] wr_data;
  int mode;

  logic               vld_a, last_a, drop_a, vld_b, last_b, drop_b;
  logic signed [13:0] data_a, data_b;
  logic [0:0]         chan_a, chan_b;
  logic [3:0]         idx_a, idx_b;
  logic [7:0]         dcnt_a, dcnt_b;

  typedef struct {
    logic [0:0]  chan;
    logic [3:0]  idx;
    logic [13:0] data;
    logic        last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  frame_buffer_pp #(.N(16), .DATA_WIDTH(14), .NCHAN(2), .BITREV(0)) dut_nat (
    .clk_i(clk), .rst_i(rst), .frame_start_i(frame_start), .wr_valid_i(wr_valid),
    .wr_data_i(wr_data), .rd_valid_o(vld_a), .rd_ready_i(rd_ready), .rd_data_o(data_a),
    .rd_chan_o(chan_a), .rd_idx_o(idx_a), .rd_last_o(last_a), .drop_o(drop_a),
    .drop_count_o(dcnt_a));

  frame_buffer_pp #(.N(16), .DATA_WIDTH(14), .NCHAN(2), .BITREV(1)) dut_rev (
    .clk_i(clk), .rst_i(rst), .frame_start_i(frame_start), .wr_valid_i(wr_valid),
    .wr_data_i(wr_data), .rd_valid_o(vld_b), .rd_ready_i(rd_ready), .rd_data_o(data_b),
    .rd_chan_o(chan_b), .rd_idx_o(idx_b), .rd_last_o(last_b), .drop_o(drop_b),
    .drop_count_o(dcnt_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int brev4(input int k);
    logic [3:0] b;
    b = k[3:0];
    return int'({b[0], b[1], b[2], b[3]});
  endfunction

  function automatic void push_frame(input int base);
    for (int ch = 0; ch < 2; ch++) begin
      for (int k = 0; k < 16; k++) begin
        exp_t e;
        int a;
        int v;
        e.chan = ch[0:0];
        e.last = (k == 15);
        v = base + k;
        if (ch == 1) v = -v;
        e.idx  = k[3:0];
        e.data = v[13:0];
        q0.push_back(e);
        a = brev4(k);
        v = base + a;
        if (ch == 1) v = -v;
        e.idx  = a[3:0];
        e.data = v[13:0];
        q1.push_back(e);
      end
    end
  endfunction

  task automatic drive(input bit start, input bit valid, input int v);
    int nv;
    nv = -v;
    frame_start = start;
    wr_valid    = valid;
    wr_data     = {nv[13:0], v[13:0]};
    @(posedge clk); #1;
    frame_start = 1'b0;
    wr_valid    = 1'b0;
  endtask

  task automatic write_frame(input int base, input int nsamp, input bit exp_drop);
    for (int i = 0; i < nsamp; i++) begin
      drive(i == 0, 1'b1, base + i);
      if (i == 0) begin
        chk("drop_pulse_nat", {31'd0, drop_a}, {31'd0, exp_drop});
        chk("drop_pulse_rev", {31'd0, drop_b}, {31'd0, exp_drop});
      end
      if (i == 1) chk("drop_clear", {31'd0, drop_a}, 32'd0);
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && (q0.size() != 0 || q1.size() != 0); i++)
      @(posedge clk);
    #1;
    chk("drain_nat", q0.size(), 32'd0);
    chk("drain_rev", q1.size(), 32'd0);
  endtask

  // Backpressure generator: 0 = always ready, 1 = random 50%, 2 = stalled
  initial begin
    rd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mode)
        1:       rd_ready = 1'($urandom_range(0, 1));
        2:       rd_ready = 1'b0;
        default: rd_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: every valid word must equal the queue head; popped on accept
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (vld_a) begin
        if (q0.size() == 0) chk("unexpected_nat", 32'd1, 32'd0);
        else begin
          e = q0[0];
          chk("chan_nat", {31'd0, chan_a}, {31'd0, e.chan});
          chk("idx_nat", {28'd0, idx_a}, {28'd0, e.idx});
          chk("data_nat", {18'd0, data_a}, {18'd0, e.data});
          chk("last_nat", {31'd0, last_a}, {31'd0, e.last});
          if (rd_ready) void'(q0.pop_front());
        end
      end
      if (vld_b) begin
        if (q1.size() == 0) chk("unexpected_rev", 32'd1, 32'd0);
        else begin
          e = q1[0];
          chk("chan_rev", {31'd0, chan_b}, {31'd0, e.chan});
          chk("idx_rev", {28'd0, idx_b}, {28'd0, e.idx});
          chk("data_rev", {18'd0, data_b}, {18'd0, e.data});
          chk("last_rev", {31'd0, last_b}, {31'd0, e.last});
          if (rd_ready) void'(q1.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; wr_valid = 1'b0; wr_data = '0; mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, vld_a}, 32'd0);
    chk("rst_data", {18'd0, data_a}, 32'd0);
    chk("rst_chan", {31'd0, chan_a}, 32'd0);
    chk("rst_idx", {28'd0, idx_a}, 32'd0);
    chk("rst_last", {31'd0, last_a}, 32'd0);
    chk("rst_drop", {31'd0, drop_a}, 32'd0);
    chk("rst_dcnt", {24'd0, dcnt_a}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Ramp frame, always ready, first-word latency
    write_frame(0, 16, 1'b0);
    push_frame(0);
    chk("lat_t0", {31'd0, vld_a}, 32'd0);
    @(posedge clk); #1;
    chk("lat_t1", {31'd0, vld_a}, 32'd0);
    @(posedge clk); #1;
    chk("lat_t2_nat", {31'd0, vld_a}, 32'd1);
    chk("lat_t2_rev", {31'd0, vld_b}, 32'd1);
    wait_drain(200);

    // Random backpressure over two back-to-back frames
    mode = 1;
    write_frame(100, 16, 1'b0);
    push_frame(100);
    write_frame(200, 16, 1'b0);
    push_frame(200);
    wait_drain(2000);

    // Reader stalled: two frames fill both banks, third start is dropped
    mode = 2;
    repeat (2) @(posedge clk);
    #1;
    write_frame(300, 16, 1'b0);
    push_frame(300);
    write_frame(400, 16, 1'b0);
    push_frame(400);
    write_frame(500, 16, 1'b1);
    chk("dcnt_after_full", {24'd0, dcnt_a}, 32'd1);
    mode = 0;
    wait_drain(300);

    // Restart after 7 samples: partial frame dropped, only the new one emerges
    write_frame(600, 7, 1'b0);
    write_frame(700, 16, 1'b1);
    chk("dcnt_after_restart", {24'd0, dcnt_a}, 32'd2);
    push_frame(700);
    wait_drain(300);

    // Reset in the middle of streaming
    write_frame(800, 16, 1'b0);
    push_frame(800);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", {31'd0, vld_a}, 32'd0);
    chk("midrst_dcnt", {24'd0, dcnt_a}, 32'd0);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    write_frame(900, 16, 1'b0);
    push_frame(900);
    wait_drain(300);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
